s2mm_packet_arbiter: RTL and testbench

Parametrised N-channel arbiter that merges per-channel first-word-fall-through FIFOs into the single AXI-Stream S2MM slave port of the MCDMA. It grants one channel per packet in round-robin order and holds that grant until the channel's last beat, so packets never interleave. A registered output stage gives full-throughput AXIS handshaking under backpressure. A per-channel enable mask gates arbitration.

---
 rtl/s2mm_packet_arbiter.sv | 135 +++++++++++++
 tb/tb_s2mm_packet_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2mm_packet_arbiter.sv
// Round-robin, packet-atomic merge of N first-word-fall-through FIFOs onto one
// AXI-Stream master with a single registered output stage.
module s2mm_packet_arbiter #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int NUM_CHANNELS    = 4
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic                                    SINK_AXIS_tready_in,
  output logic [AXIS_DATA_WIDTH-1:0]              SINK_AXIS_tdata_out,
  output logic [AXIS_DEST_WIDTH-1:0]              SINK_AXIS_tdest_out,
  output logic [AXIS_KEEP_WIDTH-1:0]              SINK_AXIS_tkeep_out,
  output logic                                    SINK_AXIS_tlast_out,
  output logic                                    SINK_AXIS_tuser_out,
  output logic                                    SINK_AXIS_tvalid_out,
  input  logic [NUM_CHANNELS*FIFO_DATA_WIDTH-1:0] fifo_data_in,
  input  logic [NUM_CHANNELS-1:0]                 fifo_not_empty_in,
  input  logic [NUM_CHANNELS-1:0]                 fifo_last_in,
  output logic [NUM_CHANNELS-1:0]                 fifo_r_stb_out,
  input  logic [NUM_CHANNELS-1:0]                 channel_mask_in,
  output logic                                    busy_out,
  output logic [AXIS_DEST_WIDTH-1:0]              active_channel_out
);

  localparam int CH_W = $clog2(NUM_CHANNELS);

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic [CH_W-1:0]            grant;
  logic [CH_W-1:0]            last_grant;
  logic [CH_W-1:0]            pick;
  logic                       found;
  logic                       load_en;
  logic                       pop;
  logic                       pop_last;
  logic [NUM_CHANNELS-1:0]    eligible;
  logic [FIFO_DATA_WIDTH-1:0] head_word;
  logic [AXIS_DATA_WIDTH-1:0] head_ext;
  logic [AXIS_DEST_WIDTH-1:0] grant_ext;

  assign eligible  = fifo_not_empty_in & channel_mask_in;
  assign load_en   = !SINK_AXIS_tvalid_out || SINK_AXIS_tready_in;
  assign head_word = fifo_data_in[int'(grant)*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];

  always_comb begin
    head_ext                       = '0;
    head_ext[FIFO_DATA_WIDTH-1:0]  = head_word;
    grant_ext                      = '0;
    grant_ext[CH_W-1:0]            = grant;
  end

  // Search upward from the channel after the previous grant, wrapping modulo N.
  always_comb begin : rr_search
    int idx;
    idx   = 0;
    pick  = last_grant;
    found = 1'b0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      idx = (int'(last_grant) + k) % NUM_CHANNELS;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    pop_last       = 1'b0;
    fifo_r_stb_out = '0;
    case (state)
      IDLE: begin
        if (found) state_next = XFER;
      end
      XFER: begin
        if (load_en && fifo_not_empty_in[grant]) begin
          pop                   = 1'b1;
          pop_last              = fifo_last_in[grant];
          fifo_r_stb_out[grant] = 1'b1;
          if (fifo_last_in[grant]) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  // Grant is held for the whole packet; the mask only matters in IDLE.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      grant      <= '0;
      last_grant <= CH_W'(NUM_CHANNELS - 1);
    end else begin
      if (state == IDLE && found) grant <= pick;
      if (pop_last)               last_grant <= grant;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      SINK_AXIS_tdata_out  <= '0;
      SINK_AXIS_tdest_out  <= '0;
      SINK_AXIS_tlast_out  <= 1'b0;
      SINK_AXIS_tvalid_out <= 1'b0;
    end else if (load_en) begin
      if (pop) begin
        SINK_AXIS_tdata_out  <= head_ext;
        SINK_AXIS_tdest_out  <= grant_ext;
        SINK_AXIS_tlast_out  <= fifo_last_in[grant];
        SINK_AXIS_tvalid_out <= 1'b1;
      end else begin
        SINK_AXIS_tvalid_out <= 1'b0;
      end
    end
  end

  assign SINK_AXIS_tkeep_out = '1;
  assign SINK_AXIS_tuser_out = 1'b0;
  assign busy_out            = (state == XFER) || SINK_AXIS_tvalid_out;
  assign active_channel_out  = grant_ext;

endmodule

// File: tb/tb_s2mm_packet_arbiter.sv
// Directed bench for s2mm_packet_arbiter: behavioural FIFOs feed the DUT and
// every accepted beat is logged with its cycle number for comparison.
module tb_s2mm_packet_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            tready;
  logic [31:0]     tdata;
  logic [3:0]      tdest;
  logic [3:0]      tkeep;
  logic            tlast;
  logic            tuser;
  logic            tvalid;
  logic [N*32-1:0] fifo_data;
  logic [N-1:0]    fifo_ne;
  logic [N-1:0]    fifo_last;
  logic [N-1:0]    fifo_r_stb;
  logic [N-1:0]    mask;
  logic            busy;
  logic [3:0]      active;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [3:0]  dest;
    logic        last;
  } beat_t;

  beat_t       beats[$];
  logic [32:0] fifo_q[N][$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          c0;
  int          c1;
  int          p2;
  int          multi_strobe = 0;
  int          pop_count[N];
  logic        log_valid[4096];
  logic        log_busy[4096];
  logic [31:0] log_data[4096];
  logic [N-1:0] log_stb[4096];

  s2mm_packet_arbiter #(
    .AXIS_DATA_WIDTH(32),
    .FIFO_DATA_WIDTH(32),
    .AXIS_KEEP_WIDTH(4),
    .AXIS_DEST_WIDTH(4),
    .NUM_CHANNELS(N)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .SINK_AXIS_tready_in(tready),
    .SINK_AXIS_tdata_out(tdata),
    .SINK_AXIS_tdest_out(tdest),
    .SINK_AXIS_tkeep_out(tkeep),
    .SINK_AXIS_tlast_out(tlast),
    .SINK_AXIS_tuser_out(tuser),
    .SINK_AXIS_tvalid_out(tvalid),
    .fifo_data_in(fifo_data),
    .fifo_not_empty_in(fifo_ne),
    .fifo_last_in(fifo_last),
    .fifo_r_stb_out(fifo_r_stb),
    .channel_mask_in(mask),
    .busy_out(busy),
    .active_channel_out(active)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifos();
    logic [32:0] h;
    for (int i = 0; i < N; i++) begin
      if (fifo_q[i].size() > 0) begin
        h = fifo_q[i][0];
        fifo_data[i*32 +: 32] = h[31:0];
        fifo_last[i]          = h[32];
        fifo_ne[i]            = 1'b1;
      end else begin
        fifo_data[i*32 +: 32] = '0;
        fifo_last[i]          = 1'b0;
        fifo_ne[i]            = 1'b0;
      end
    end
  endtask

  task automatic push(input int ch, input logic [31:0] d, input logic l);
    fifo_q[ch].push_back({l, d});
  endtask

  // Each cycle: sample just before the edge, then pop after it and re-drive heads.
  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      logic [N-1:0] popped;
      #3;
      popped = fifo_r_stb;
      if (cyc < 4096) begin
        log_valid[cyc] = tvalid;
        log_busy[cyc]  = busy;
        log_data[cyc]  = tdata;
        log_stb[cyc]   = fifo_r_stb;
      end
      if ($countones(popped) > 1) multi_strobe++;
      if (tvalid && tready) beats.push_back('{cyc, tdata, tdest, tlast});
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (popped[i]) begin
          pop_count[i]++;
          if (fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
        end
      end
      drive_fifos();
    end
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #2;
    checkOutput({tag, "_tvalid"}, 64'(tvalid), 64'd0);
    checkOutput({tag, "_tdata"},  64'(tdata),  64'd0);
    checkOutput({tag, "_tdest"},  64'(tdest),  64'd0);
    checkOutput({tag, "_tlast"},  64'(tlast),  64'd0);
    checkOutput({tag, "_stb"},    64'(fifo_r_stb), 64'd0);
    checkOutput({tag, "_busy"},   64'(busy),   64'd0);
    checkOutput({tag, "_active"}, 64'(active), 64'd0);
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
  endtask

  task automatic check_beat(input string tag, input int j, input int base, input int off,
                            input logic [31:0] d, input logic [3:0] dest, input logic l);
    beat_t b;
    if (j < beats.size()) b = beats[j];
    else                  b = '{-1, 32'hDEAD_BEEF, 4'hF, 1'bx};
    checkOutput($sformatf("%s_b%0d_cyc",  tag, j), 64'(b.cyc - base), 64'(off));
    checkOutput($sformatf("%s_b%0d_data", tag, j), 64'(b.data), 64'(d));
    checkOutput($sformatf("%s_b%0d_dest", tag, j), 64'(b.dest), 64'(dest));
    checkOutput($sformatf("%s_b%0d_last", tag, j), 64'(b.last), 64'(l));
  endtask

  initial begin
    tready    = 1'b1;
    mask      = '1;
    fifo_data = '0;
    fifo_ne   = '0;
    fifo_last = '0;
    for (int i = 0; i < N; i++) pop_count[i] = 0;

    apply_reset("rst0");
    checkOutput("rst0_tkeep", 64'(tkeep), 64'hF);
    checkOutput("rst0_tuser", 64'(tuser), 64'd0);
    drive_fifos();

    // Single 3-word packet on channel 2
    beats.delete();
    push(2, 32'hAAAA_0001, 1'b0);
    push(2, 32'hAAAA_0002, 1'b0);
    push(2, 32'hAAAA_0003, 1'b1);
    drive_fifos();
    c0 = cyc;
    applyStimulus(8);
    checkOutput("s1_count", 64'(beats.size()), 64'd3);
    check_beat("s1", 0, c0, 2, 32'hAAAA_0001, 4'd2, 1'b0);
    check_beat("s1", 1, c0, 3, 32'hAAAA_0002, 4'd2, 1'b0);
    check_beat("s1", 2, c0, 4, 32'hAAAA_0003, 4'd2, 1'b1);
    checkOutput("s1_active", 64'(active), 64'd2);

    // Round robin from reset: 2-beat packets on all channels
    apply_reset("rst1");
    beats.delete();
    for (int k = 0; k < N; k++) begin
      push(k, 32'h2000_0000 | 32'(k << 4), 1'b0);
      push(k, 32'h2000_0001 | 32'(k << 4), 1'b1);
    end
    drive_fifos();
    c0 = cyc;
    applyStimulus(16);
    checkOutput("s2_count", 64'(beats.size()), 64'd8);
    for (int j = 0; j < 8; j++) begin
      check_beat("s2", j, c0, 2 + 3*(j/2) + (j%2),
                 32'h2000_0000 | 32'((j/2) << 4) | 32'(j%2), 4'(j/2), 1'(j%2));
    end
    checkOutput("s2_gap0", 64'(log_valid[c0+4]), 64'd0);
    checkOutput("s2_gap2", 64'(log_valid[c0+10]), 64'd0);

    // Backpressure on ch0 (also the wrap after ch3), then ch3
    beats.delete();
    for (int w = 0; w < 4; w++) push(0, 32'hD000_0000 + 32'(w), 1'(w == 3));
    push(3, 32'hE000_0000, 1'b1);
    drive_fifos();
    c0 = cyc;
    tready = 1'b1;
    applyStimulus(3);
    tready = 1'b0;
    applyStimulus(2);
    tready = 1'b1;
    applyStimulus(8);
    checkOutput("s3_count", 64'(beats.size()), 64'd5);
    check_beat("s3", 0, c0, 2, 32'hD000_0000, 4'd0, 1'b0);
    check_beat("s3", 1, c0, 5, 32'hD000_0001, 4'd0, 1'b0);
    check_beat("s3", 2, c0, 6, 32'hD000_0002, 4'd0, 1'b0);
    check_beat("s3", 3, c0, 7, 32'hD000_0003, 4'd0, 1'b1);
    check_beat("s3", 4, c0, 9, 32'hE000_0000, 4'd3, 1'b1);
    checkOutput("s3_stall_stb0",   64'(log_stb[c0+3]),   64'd0);
    checkOutput("s3_stall_stb1",   64'(log_stb[c0+4]),   64'd0);
    checkOutput("s3_stall_data0",  64'(log_data[c0+3]),  64'hD000_0001);
    checkOutput("s3_stall_data1",  64'(log_data[c0+4]),  64'hD000_0001);
    checkOutput("s3_stall_valid",  64'(log_valid[c0+4]), 64'd1);

    // Mask: ch2 excluded, ch0 mask dropped mid-packet
    beats.delete();
    mask = 4'b1011;
    push(2, 32'hF000_0000, 1'b1);
    for (int w = 0; w < 3; w++) push(0, 32'h6000_0000 + 32'(w), 1'(w == 2));
    drive_fifos();
    c0 = cyc;
    p2 = pop_count[2];
    applyStimulus(2);
    mask = 4'b1010;
    applyStimulus(8);
    checkOutput("s4_count", 64'(beats.size()), 64'd3);
    check_beat("s4", 0, c0, 2, 32'h6000_0000, 4'd0, 1'b0);
    check_beat("s4", 1, c0, 3, 32'h6000_0001, 4'd0, 1'b0);
    check_beat("s4", 2, c0, 4, 32'h6000_0002, 4'd0, 1'b1);
    checkOutput("s4_ch2_pops", 64'(pop_count[2] - p2), 64'd0);
    checkOutput("s4_ch2_left", 64'(fifo_q[2].size()), 64'd1);
    fifo_q[2].delete();
    mask = '1;
    drive_fifos();

    // Underrun on ch1 with ch3 waiting
    beats.delete();
    push(1, 32'h1100_0000, 1'b0);
    push(1, 32'h1100_0001, 1'b0);
    push(3, 32'h3300_0000, 1'b1);
    drive_fifos();
    c0 = cyc;
    applyStimulus(7);
    push(1, 32'h1100_0002, 1'b1);
    drive_fifos();
    applyStimulus(8);
    checkOutput("s5_count", 64'(beats.size()), 64'd4);
    check_beat("s5", 0, c0, 2,  32'h1100_0000, 4'd1, 1'b0);
    check_beat("s5", 1, c0, 3,  32'h1100_0001, 4'd1, 1'b0);
    check_beat("s5", 2, c0, 8,  32'h1100_0002, 4'd1, 1'b1);
    check_beat("s5", 3, c0, 10, 32'h3300_0000, 4'd3, 1'b1);
    checkOutput("s5_valid_drop", 64'(log_valid[c0+5]), 64'd0);
    checkOutput("s5_busy_hold",  64'(log_busy[c0+5]),  64'd1);
    checkOutput("s5_no_stb",     64'(log_stb[c0+5]),   64'd0);

    // Asynchronous reset in the middle of a ch2 packet
    beats.delete();
    mask = 4'b0100;
    for (int w = 0; w < 4; w++) push(2, 32'h7700_0000 + 32'(w), 1'(w == 3));
    drive_fifos();
    c0 = cyc;
    applyStimulus(3);
    #2;
    checkOutput("s6_pre_valid", 64'(tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_valid", 64'(tvalid), 64'd0);
    checkOutput("s6_rst_stb",   64'(fifo_r_stb), 64'd0);
    checkOutput("s6_rst_busy",  64'(busy), 64'd0);
    checkOutput("s6_rst_data",  64'(tdata), 64'd0);
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    mask  = '1;
    push(1, 32'h9900_0000, 1'b1);
    drive_fifos();
    beats.delete();
    c1 = cyc;
    applyStimulus(8);
    check_beat("s6", 0, c1, 2, 32'h9900_0000, 4'd1, 1'b1);
    check_beat("s6", 1, c1, 4, 32'h7700_0002, 4'd2, 1'b0);

    checkOutput("multi_strobe", 64'(multi_strobe), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
